// File: rtl/adc_cfg_seq.sv
// Serial-configuration sequencer for the two shared-bus 14-bit ADCs: hardware reset pulse,
// init-table download, then arbitration of single host register writes onto SEN/SCLK/SDAT.
module adc_cfg_seq #(
   parameter  int NREG      = 4,
   parameter  int CLK_DIV   = 32,
   parameter  int RST_PULSE = 255,
   parameter  int RST_WAIT  = 1024,
   parameter  int GAP       = 32,
   localparam int IW        = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [IW-1:0] tbl_idx,
   input  logic [15:0]   tbl_word,
   input  logic          wr_req,
   input  logic [7:0]    wr_addr,
   input  logic [7:0]    wr_data,
   output logic          wr_ack,
   output logic          busy,
   output logic          init_done,
   output logic          adc_reset,
   output logic          adc_sen_n,
   output logic          adc_sclk,
   output logic          adc_sdat
);

   localparam int HW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int WM1  = (RST_PULSE > RST_WAIT) ? RST_PULSE : RST_WAIT;
   localparam int WMAX = (WM1 > GAP) ? WM1 : GAP;
   localparam int CW   = $clog2(WMAX + 1);

   localparam logic [HW-1:0] H_LAST     = HW'(CLK_DIV - 1);
   localparam logic [CW-1:0] PULSE_LAST = CW'(RST_PULSE - 1);
   localparam logic [CW-1:0] WAIT_LAST  = CW'(RST_WAIT - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NREG - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RST_HI, S_RST_WAIT, S_LOAD, S_SHIFT, S_GAP_W
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [HW-1:0] hcnt, hcnt_n;
   logic [3:0]    bcnt, bcnt_n, bit_nxt;
   logic          ph, ph_n;
   logic          src_host, src_host_n;
   logic [IW-1:0] idx_n;
   logic          ack_n, done_n, arst_n, sen_n_n, sclk_n, sdat_n;
   logic          host_accept;
   logic [15:0]   host_word, sreg, load_word;

   // A request seen in the ack cycle belongs to the frame just finished.
   assign host_accept = (state == S_IDLE) && !start && wr_req && !wr_ack;
   assign load_word   = src_host ? host_word : tbl_word;
   assign bit_nxt     = bcnt - 4'd1;

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      hcnt_n     = hcnt;
      bcnt_n     = bcnt;
      ph_n       = ph;
      src_host_n = src_host;
      idx_n      = tbl_idx;
      ack_n      = 1'b0;
      done_n     = init_done;
      arst_n     = adc_reset;
      sen_n_n    = adc_sen_n;
      sclk_n     = adc_sclk;
      sdat_n     = adc_sdat;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_RST_HI;
               arst_n  = 1'b1;
               cnt_n   = '0;
            end else if (host_accept) begin
               state_n    = S_LOAD;
               src_host_n = 1'b1;
            end
         end
         S_RST_HI: begin
            if (cnt == PULSE_LAST) begin
               state_n = S_RST_WAIT;
               arst_n  = 1'b0;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_RST_WAIT: begin
            if (cnt == WAIT_LAST) begin
               state_n    = S_LOAD;
               idx_n      = '0;
               src_host_n = 1'b0;
               cnt_n      = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_LOAD: begin
            state_n = S_SHIFT;
            sen_n_n = 1'b0;
            sclk_n  = 1'b0;
            sdat_n  = load_word[15];
            hcnt_n  = '0;
            ph_n    = 1'b0;
            bcnt_n  = 4'd15;
         end
         S_SHIFT: begin
            // ph=0 is the SCLK-low half carrying bit bcnt; SDAT only moves as SCLK falls.
            if (hcnt != H_LAST) begin
               hcnt_n = hcnt + 1'b1;
            end else begin
               hcnt_n = '0;
               if (!ph) begin
                  ph_n   = 1'b1;
                  sclk_n = 1'b1;
               end else if (bcnt == 4'd0) begin
                  state_n = S_GAP_W;
                  sen_n_n = 1'b1;
                  sclk_n  = 1'b1;
                  sdat_n  = 1'b0;
                  ph_n    = 1'b0;
                  bcnt_n  = 4'd15;
                  cnt_n   = '0;
               end else begin
                  ph_n   = 1'b0;
                  sclk_n = 1'b0;
                  bcnt_n = bit_nxt;
                  sdat_n = sreg[bit_nxt];
               end
            end
         end
         S_GAP_W: begin
            if (cnt != GAP_LAST) begin
               cnt_n = cnt + 1'b1;
            end else begin
               cnt_n = '0;
               if (src_host) begin
                  ack_n   = 1'b1;
                  state_n = S_IDLE;
               end else if (tbl_idx != IDX_LAST) begin
                  idx_n   = tbl_idx + 1'b1;
                  state_n = S_LOAD;
               end else begin
                  done_n  = 1'b1;
                  idx_n   = '0;
                  state_n = S_IDLE;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         hcnt      <= '0;
         bcnt      <= 4'd15;
         ph        <= 1'b0;
         src_host  <= 1'b0;
         tbl_idx   <= '0;
         wr_ack    <= 1'b0;
         busy      <= 1'b0;
         init_done <= 1'b0;
         adc_reset <= 1'b0;
         adc_sen_n <= 1'b1;
         adc_sclk  <= 1'b1;
         adc_sdat  <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         hcnt      <= hcnt_n;
         bcnt      <= bcnt_n;
         ph        <= ph_n;
         src_host  <= src_host_n;
         tbl_idx   <= idx_n;
         wr_ack    <= ack_n;
         busy      <= (state_n != S_IDLE);
         init_done <= done_n;
         adc_reset <= arst_n;
         adc_sen_n <= sen_n_n;
         adc_sclk  <= sclk_n;
         adc_sdat  <= sdat_n;
      end
   end

   // Frame data path carries no reset; it is always loaded before use.
   always_ff @(posedge clk) begin
      if (host_accept) host_word <= {wr_addr, wr_data};
      if (state == S_LOAD) sreg <= load_word;
   end

endmodule
